// File: rtl/gate_range_ctrl_pkg.sv
// Shared types and constants for the gate/range controller: FSM states,
// range codes, auto-range thresholds and the gate-length helper.
package gate_range_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    GATE,
    SETTLE,
    STORE,
    RANGE
  } state_t;

  localparam logic [1:0] R_X1    = 2'b00;
  localparam logic [1:0] R_X10   = 2'b01;
  localparam logic [1:0] R_X100  = 2'b10;
  localparam logic [1:0] R_X1000 = 2'b11;

  // Below LO_LIM steps up a range, above HI_LIM steps down; the gap is the hysteresis.
  localparam logic [15:0] LO_LIM = 16'd1000;
  localparam logic [15:0] HI_LIM = 16'd9999;

  function automatic logic [31:0] gate_len(input logic [31:0] base, input logic [1:0] rng);
    case (rng)
      R_X1:    return base;
      R_X10:   return base * 32'd10;
      R_X100:  return base * 32'd100;
      default: return base * 32'd1000;
    endcase
  endfunction

endpackage

// File: rtl/gate_range_ctrl_gate_timer.sv
// Loadable 32-bit down-counter; done is high while the count sits at zero.
module gate_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        done
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 32'd0) begin
      count <= count - 32'd1;
    end
  end

  assign done = (count == 32'd0);

endmodule

// File: rtl/gate_range_ctrl.sv
// Gate/store sequencer with auto-ranging for a reciprocal-free frequency counter.
// Auto-ranging is compiled in only when AUTO_RANGE_EN is defined; otherwise the range is manual.
//
// state  | meaning
// IDLE   | waiting for Run; manual range tracks F_man
// CLR    | one-cycle Clear pulse, gate timer loaded
// GATE   | counting window open for GATE_BASE*10^F_sel cycles
// SETTLE | counter settles; N/Ovf captured on the last cycle
// STORE  | one-cycle Store strobe, F_sel still the range just used
// RANGE  | range update, then next CLR or back to IDLE
module gate_range_ctrl
  import gate_range_ctrl_pkg::*;
#(
  parameter int unsigned GATE_BASE  = 50000,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        Run,
  input  logic        Auto,
  input  logic [1:0]  F_man,
  input  logic [15:0] N,
  input  logic        Ovf,
  output logic        Gate,
  output logic        Clear,
  output logic        Store,
  output logic [1:0]  F_sel,
  output logic        OvRange
);

  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYC - 1);

  state_t      state;
  logic        t_load;
  logic [31:0] t_val;
  logic        t_done;
  logic [15:0] n_cap;
  logic        ovf_cap;
  logic        ov;
  logic        auto_mode;

`ifdef AUTO_RANGE_EN
  assign auto_mode = Auto;
`else
  logic unused_auto;
  assign unused_auto = Auto;
  assign auto_mode   = 1'b0;
`endif

  assign ov = ovf_cap | (n_cap > HI_LIM);

  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    if (state == CLR) begin
      t_load = 1'b1;
      t_val  = gate_len(GATE_BASE, F_sel) - 32'd1;
    end else if (state == GATE && t_done) begin
      t_load = 1'b1;
      t_val  = SETTLE_LOAD;
    end
  end

  gate_timer u_timer (
    .clk      (CLK),
    .rst_n    (nRST),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      Gate    <= 1'b0;
      Clear   <= 1'b0;
      Store   <= 1'b0;
      F_sel   <= R_X100;
      OvRange <= 1'b0;
      n_cap   <= '0;
      ovf_cap <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!auto_mode) F_sel <= F_man;
          if (Run) begin
            state <= CLR;
            Clear <= 1'b1;
          end
        end
        CLR: begin
          Clear <= 1'b0;
          Gate  <= 1'b1;
          state <= GATE;
        end
        GATE: begin
          if (t_done) begin
            Gate  <= 1'b0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (t_done) begin
            n_cap   <= N;
            ovf_cap <= Ovf;
            Store   <= 1'b1;
            state   <= STORE;
          end
        end
        STORE: begin
          Store <= 1'b0;
          state <= RANGE;
        end
        RANGE: begin
          if (auto_mode) begin
            if (ov) begin
              // Only an overflow that cannot be cured by a shorter gate flags OvRange.
              if (F_sel != R_X1) begin
                F_sel   <= F_sel - 2'd1;
                OvRange <= 1'b0;
              end else begin
                OvRange <= 1'b1;
              end
            end else begin
              OvRange <= 1'b0;
              if (n_cap < LO_LIM && F_sel != R_X1000) F_sel <= F_sel + 2'd1;
            end
          end else begin
            // Manual range: OvRange reports an overflow on whichever range was selected.
            F_sel   <= F_man;
            OvRange <= ov;
          end
          if (Run) begin
            state <= CLR;
            Clear <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          Gate  <= 1'b0;
          Clear <= 1'b0;
          Store <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_range_ctrl.sv
// Directed bench for gate_range_ctrl (GATE_BASE=10, SETTLE_CYC=2); auto-range
// expectations apply when AUTO_RANGE_EN is defined, manual ones otherwise.
module tb_gate_range_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        Run = 1'b0;
  logic        Auto = 1'b0;
  logic [1:0]  F_man = 2'b01;
  logic [15:0] N = 16'd0;
  logic        Ovf = 1'b0;
  logic        Gate, Clear, Store, OvRange;
  logic [1:0]  F_sel;

  int checks = 0;
  int failures = 0;

  gate_range_ctrl #(.GATE_BASE(10), .SETTLE_CYC(2)) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .Run     (Run),
    .Auto    (Auto),
    .F_man   (F_man),
    .N       (N),
    .Ovf     (Ovf),
    .Gate    (Gate),
    .Clear   (Clear),
    .Store   (Store),
    .F_sel   (F_sel),
    .OvRange (OvRange)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_meas(output int clr_n, output int gate_n, output int gap_n,
                         output int str_n, output logic [1:0] fs);
    int t;
    t = 0;
    clr_n = 0; gate_n = 0; gap_n = 0; str_n = 0; fs = 2'b00;
    while (!Clear && t < 200) begin @(negedge CLK); t++; end
    if (!Clear) begin
      chk("clear_timeout", 32'd0, 32'd1);
      return;
    end
    while (Clear && clr_n < 10) begin clr_n++; @(negedge CLK); end
    while (Gate && gate_n < 20000) begin gate_n++; @(negedge CLK); end
    while (!Store && gap_n < 50) begin gap_n++; @(negedge CLK); end
    fs = F_sel;
    while (Store && str_n < 10) begin str_n++; @(negedge CLK); end
  endtask

  // One full measurement plus the range result visible one cycle after RANGE.
  task automatic meas(input string tag, input int exp_gate, input logic [1:0] exp_fs,
                      input logic [1:0] exp_after, input logic chk_ov, input logic exp_ov);
    int c, g, s, w;
    logic [1:0] fs;
    do_meas(c, g, s, w, fs);
    chk({tag, "_clear_len"}, c, 1);
    chk({tag, "_gate_len"}, g, exp_gate);
    chk({tag, "_settle_gap"}, s, 2);
    chk({tag, "_store_len"}, w, 1);
    chk({tag, "_fsel_at_store"}, {30'd0, fs}, {30'd0, exp_fs});
    @(negedge CLK);
    chk({tag, "_fsel_after"}, {30'd0, F_sel}, {30'd0, exp_after});
    if (chk_ov) chk({tag, "_ovrange"}, {31'd0, OvRange}, {31'd0, exp_ov});
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    int t, stores, clears;
    repeat (2) @(negedge CLK);
    chk("rst_gate", {31'd0, Gate}, 0);
    chk("rst_clear", {31'd0, Clear}, 0);
    chk("rst_store", {31'd0, Store}, 0);
    chk("rst_fsel", {30'd0, F_sel}, 2);
    chk("rst_ovrange", {31'd0, OvRange}, 0);
    nRST = 1'b1;
    @(negedge CLK);

    // Manual x10 range, single Run pulse
    Run = 1'b1;
    @(negedge CLK);
    Run = 1'b0;
    meas("man01", 100, 2'b01, 2'b01, 1'b0, 1'b0);
    chk("man01_idle_gate", {31'd0, Gate}, 0);
    clears = 0;
    repeat (5) begin @(negedge CLK); if (Clear) clears++; end
    chk("man01_idle_noclear", clears, 0);

`ifdef AUTO_RANGE_EN
    Auto = 1'b1; Run = 1'b1; N = 16'd12000; Ovf = 1'b0;
    do_reset();
    meas("a_hi10", 1000, 2'b10, 2'b01, 1'b0, 1'b0);
    N = 16'd9999;
    meas("a_9999", 100, 2'b01, 2'b01, 1'b1, 1'b0);
    N = 16'd1000;
    meas("a_1000", 100, 2'b01, 2'b01, 1'b1, 1'b0);
    N = 16'd12000;
    meas("a_hi01", 100, 2'b01, 2'b00, 1'b0, 1'b0);
    N = 16'd100; Ovf = 1'b1;
    meas("a_ovf00", 10, 2'b00, 2'b00, 1'b1, 1'b1);
    N = 16'd500; Ovf = 1'b0;
    meas("a_500", 10, 2'b00, 2'b01, 1'b1, 1'b0);
    N = 16'd5;
    meas("a_lo01", 100, 2'b01, 2'b10, 1'b0, 1'b0);
    meas("a_lo10", 1000, 2'b10, 2'b11, 1'b0, 1'b0);
    meas("a_lo11", 10000, 2'b11, 2'b11, 1'b0, 1'b0);
    N = 16'd5000; Run = 1'b0;
    meas("a_mid11", 10000, 2'b11, 2'b11, 1'b1, 1'b0);
`else
    Auto = 1'b1; F_man = 2'b00; Run = 1'b1; N = 16'd12000; Ovf = 1'b0;
    do_reset();
    meas("m_ovf00", 10, 2'b00, 2'b00, 1'b1, 1'b1);
    F_man = 2'b11; N = 16'd500; Run = 1'b0;
    meas("m_500", 10, 2'b00, 2'b11, 1'b1, 1'b0);
`endif

    // Reset in the middle of a gate
    Auto = 1'b0; F_man = 2'b01; N = 16'd5000; Ovf = 1'b0; Run = 1'b1;
    do_reset();
    t = 0;
    while (!Gate && t < 50) begin @(negedge CLK); t++; end
    chk("rst_mid_gate_seen", {31'd0, Gate}, 1);
    repeat (40) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("rst_mid_gate_drop", {31'd0, Gate}, 0);
    chk("rst_mid_fsel", {30'd0, F_sel}, 2);
    stores = 0;
    repeat (3) begin @(negedge CLK); if (Store) stores++; end
    chk("rst_mid_nostore", stores, 0);
    nRST = 1'b1;
    meas("rst_rerun", 100, 2'b01, 2'b01, 1'b0, 1'b0);

    // Run dropped mid-gate: cycle completes once, then idles
    t = 0;
    while (!Gate && t < 50) begin @(negedge CLK); t++; end
    chk("drop_gate_seen", {31'd0, Gate}, 1);
    repeat (3) @(negedge CLK);
    Run = 1'b0;
    stores = 0; clears = 0;
    repeat (200) begin
      @(negedge CLK);
      if (Store) stores++;
      if (Clear) clears++;
    end
    chk("drop_one_store", stores, 1);
    chk("drop_no_clear", clears, 0);
    chk("drop_idle_gate", {31'd0, Gate}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
